// File: rtl/soc2_uart_pkg.sv
// soc2_uart_pkg: shared types and parameter defaults for the soc2 UART receiver.
// Optional feature macro used by the receiver: SOC2_UART_RX_PARITY_EN.
package soc2_uart_pkg;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_OVS        = 16;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_DIV_W      = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

endpackage

// File: rtl/soc2_uart_rx_if.sv
// soc2_uart_rx_if: receive-FIFO read port of the UART receiver.
// slave = receiver side, master = consumer side.
interface soc2_uart_rx_if
   import soc2_uart_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
   logic                          rd_en;
   logic [DATA_W-1:0]             rd_data;
   logic                          rd_valid;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   modport master (output rd_en, input rd_data, input rd_valid, input fifo_count);
   modport slave  (input rd_en, output rd_data, output rd_valid, output fifo_count);
endinterface

// File: rtl/soc2_sync_fifo.sv
// soc2_sync_fifo: single-clock first-word-fall-through FIFO.
// A push into a full FIFO only completes when a pop happens in the same cycle.
module soc2_sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic              do_push_s;
   logic              do_pop_s;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);
   assign rd_data   = mem_q[rd_ptr_q];
   assign count     = count_q;

   // Next occupancy from the qualified push/pop pair.
   always_comb begin
      count_d = count_q;
      if (do_push_s && !do_pop_s) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop_s && !do_push_s) begin
         count_d = count_q - CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Storage array write; contents need no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/soc2_uart_rx.sv
// soc2_uart_rx: oversampling UART receiver with a receive FIFO and sticky error flags.
// Optional parity stage enabled by defining SOC2_UART_RX_PARITY_EN.
module soc2_uart_rx
   import soc2_uart_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int OVS        = DEF_OVS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int DIV_W      = DEF_DIV_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [DIV_W-1:0]  baud_div,
   input  logic              uart_rx,
   input  logic              parity_odd,
   input  logic              clr_err,
   output logic              frame_err,
   output logic              parity_err,
   output logic              overrun,
   soc2_uart_rx_if.slave     rd_if
);
   localparam int OS_W = $clog2(OVS);
   localparam int BC_W = $clog2(DATA_W);
   localparam logic [OS_W-1:0] HALF_LAST = OS_W'(OVS/2 - 1);
   localparam logic [OS_W-1:0] FULL_LAST = OS_W'(OVS - 1);
   localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(DATA_W - 1);

   logic              rx_meta_q, rx_sync_q;
   logic [DIV_W-1:0]  div_cnt_q;
   logic [DIV_W-1:0]  div_eff_s;
   logic              tick_s;
   rx_state_e         state_q;
   logic [OS_W-1:0]   os_cnt_q;
   logic [BC_W-1:0]   bit_cnt_q;
   logic [DATA_W-1:0] shift_q;
   logic              bad_q;
   logic              frame_err_q, overrun_q;
   logic              stop_smp_s, push_s, frame_evt_s, ovr_evt_s, par_bad_s;
   logic              fifo_full_s, fifo_empty_s;

   // Two-flop synchroniser for the asynchronous line, idles high.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // A divisor of zero behaves as one; >= keeps the tick alive if the divisor shrinks.
   assign div_eff_s = (baud_div == '0) ? DIV_W'(1) : baud_div;
   assign tick_s    = (div_cnt_q >= div_eff_s - DIV_W'(1));

   // Free-running oversample tick counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
      end else if (tick_s) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
   end

`ifdef SOC2_UART_RX_PARITY_EN
   // Parity bit must make the total number of ones match the selected sense.
   function automatic logic parity_mismatch(input logic [DATA_W-1:0] d, input logic pbit,
                                            input logic odd);
      return ((^d) ^ pbit) != odd;
   endfunction
   assign par_bad_s = (state_q == ST_PARITY) && tick_s && (os_cnt_q == FULL_LAST) &&
                      parity_mismatch(shift_q, rx_sync_q, parity_odd);
`else
   logic unused_parity_odd_s;
   assign unused_parity_odd_s = parity_odd;
   assign par_bad_s = 1'b0;
`endif

   // Frame receive FSM; every transition happens on an oversample tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         os_cnt_q  <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         bad_q     <= 1'b0;
      end else if (tick_s) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_sync_q) begin
                  state_q  <= ST_START;
                  os_cnt_q <= '0;
                  bad_q    <= 1'b0;
               end
            end
            ST_START: begin
               if (os_cnt_q == HALF_LAST) begin
                  os_cnt_q  <= '0;
                  bit_cnt_q <= '0;
                  state_q   <= rx_sync_q ? ST_IDLE : ST_DATA;
               end else begin
                  os_cnt_q <= os_cnt_q + OS_W'(1);
               end
            end
            ST_DATA: begin
               if (os_cnt_q == FULL_LAST) begin
                  os_cnt_q <= '0;
                  shift_q  <= {rx_sync_q, shift_q[DATA_W-1:1]};
                  if (bit_cnt_q == LAST_BIT) begin
`ifdef SOC2_UART_RX_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BC_W'(1);
                  end
               end else begin
                  os_cnt_q <= os_cnt_q + OS_W'(1);
               end
            end
            ST_PARITY: begin
               if (os_cnt_q == FULL_LAST) begin
                  os_cnt_q <= '0;
                  if (par_bad_s) bad_q <= 1'b1;
                  state_q <= ST_STOP;
               end else begin
                  os_cnt_q <= os_cnt_q + OS_W'(1);
               end
            end
            ST_STOP: begin
               if (os_cnt_q == FULL_LAST) begin
                  os_cnt_q <= '0;
                  state_q  <= ST_IDLE;
               end else begin
                  os_cnt_q <= os_cnt_q + OS_W'(1);
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               os_cnt_q <= '0;
            end
         endcase
      end
   end

   // Stop-bit sample decides push vs. framing error in the same clock.
   assign stop_smp_s  = (state_q == ST_STOP) && tick_s && (os_cnt_q == FULL_LAST);
   assign push_s      = stop_smp_s && rx_sync_q && !bad_q;
   assign frame_evt_s = stop_smp_s && !rx_sync_q;
   assign ovr_evt_s   = push_s && fifo_full_s && !rd_if.rd_en;

   // Sticky error flags; a new event wins over a coincident clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (frame_evt_s)  frame_err_q <= 1'b1;
         else if (clr_err) frame_err_q <= 1'b0;
         if (ovr_evt_s)    overrun_q   <= 1'b1;
         else if (clr_err) overrun_q   <= 1'b0;
      end
   end

`ifdef SOC2_UART_RX_PARITY_EN
   logic parity_err_q;
   // Sticky parity flag with the same event-over-clear priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         parity_err_q <= 1'b0;
      end else if (par_bad_s) begin
         parity_err_q <= 1'b1;
      end else if (clr_err) begin
         parity_err_q <= 1'b0;
      end
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

   soc2_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_s),
      .wr_data (shift_q),
      .pop     (rd_if.rd_en),
      .rd_data (rd_if.rd_data),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .count   (rd_if.fifo_count)
   );

   assign rd_if.rd_valid = ~fifo_empty_s;
endmodule
